// File: rtl/data_demux_pkg.sv
// -----------------------------------------------------------------------------
// data_demux_pkg
//   Shared constants and types for the data_demux block and its slot
//   sub-module.
//
//   NCH          : number of output channels (selects 0..NCH-1)
//   DW_DEFAULT   : default data word width
//   SEL_W        : width of the channel select
//   SEL_ILLEGAL  : select code that is never a channel; words sent to it
//                  are discarded
//   slot_state_e : one-entry slot state encoding (EMPTY=0, FULL=1)
// -----------------------------------------------------------------------------
package data_demux_pkg;

  localparam int NCH        = 7;
  localparam int DW_DEFAULT = 32;
  localparam int SEL_W      = 3;

  localparam logic [SEL_W-1:0] SEL_ILLEGAL = 3'b111;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // True when a select code addresses a real channel.
  function automatic logic sel_is_legal(input logic [SEL_W-1:0] sel);
    return sel != SEL_ILLEGAL;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
//   One-entry output register for a single demux channel. Holds at most one
//   word; a load while the held word is being drained replaces it in the same
//   cycle, so a channel sustains one word per clock with no bubble.
//
// Parameters
//   DW        : data width
// Ports
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-high reset (slot EMPTY, data 0)
//   load      : write load_data into the slot this cycle
//   drain     : sink ready; together with valid the held word leaves
//   load_data : word to store
//   valid     : slot is FULL (registered)
//   can_load  : slot can take a word this cycle (EMPTY, or FULL and draining)
//   data      : held word (registered; keeps last value when EMPTY)
// -----------------------------------------------------------------------------
module demux_slot
  import data_demux_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          drain,
  input  logic [DW-1:0] load_data,
  output logic          valid,
  output logic          can_load,
  output logic [DW-1:0] data
);

  slot_state_e   state_q, state_d;
  logic [DW-1:0] data_q,  data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A load always wins: on a simultaneous drain the slot stays FULL and is
  // refilled with the new word. A drain without a load empties the slot but
  // leaves the data register untouched.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = load_data;
    end else if ((state_q == SLOT_FULL) && drain) begin
      state_d = SLOT_EMPTY;
    end
  end

  assign valid    = (state_q == SLOT_FULL);
  assign can_load = (state_q == SLOT_EMPTY) || drain;
  assign data     = data_q;

endmodule

// File: rtl/data_demux.sv
// -----------------------------------------------------------------------------
// data_demux
//   Routes each accepted input word to one of NCH output channels selected by
//   in_sel. Every channel owns a one-entry slot (demux_slot), so a stalled
//   channel only blocks inputs that select it. Select SEL_ILLEGAL is always
//   accepted and the word is discarded.
//
// Build option
//   DATA_DEMUX_ERR_EN : when defined, accepting an illegal select sets the
//                       sticky err_sel flag (cleared only by rst). When not
//                       defined, err_sel is tied 0.
//
// Parameters
//   DW        : data width
//   NCH       : number of channels (at most 7, selects 0..NCH-1)
// Ports
//   clk       : clock
//   rst       : synchronous active-high reset
//   in_valid  : in_data/in_sel presented
//   in_ready  : word accepted this cycle when high together with in_valid
//   in_data   : word to route
//   in_sel    : destination channel, 3'b111 illegal
//   out_valid : per-channel valid (registered)
//   out_ready : per-channel sink ready
//   out_data  : channel k at bits [k*DW +: DW] (registered)
//   err_sel   : sticky illegal-select flag
// -----------------------------------------------------------------------------
module data_demux #(
  parameter int DW  = data_demux_pkg::DW_DEFAULT,
  parameter int NCH = data_demux_pkg::NCH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DW-1:0]                   in_data,
  input  logic [data_demux_pkg::SEL_W-1:0] in_sel,
  output logic [NCH-1:0]                  out_valid,
  input  logic [NCH-1:0]                  out_ready,
  output logic [NCH*DW-1:0]               out_data,
  output logic                            err_sel
);

  localparam int NSEL = 1 << data_demux_pkg::SEL_W;

  // Per-select-code "can take a word" flags. Codes with no channel behind
  // them (including SEL_ILLEGAL) read as ready so such words are consumed
  // and dropped instead of stalling the input. Indexing this full-width
  // vector by in_sel never goes out of range.
  logic [NSEL-1:0] ready_pad;
  logic [NCH-1:0]  slot_load;
  logic            accept;

  // in_ready never looks at in_valid, so a source may wait for ready first.
  assign in_ready = (!data_demux_pkg::sel_is_legal(in_sel)) | ready_pad[in_sel];

  // No word is taken while reset is asserted, even if in_ready is high.
  assign accept = in_valid & in_ready & ~rst;

  genvar gi;
  generate
    for (gi = 0; gi < NSEL; gi++) begin : g_sel
      if (gi < NCH) begin : g_ch
        assign slot_load[gi] = accept &&
                               (in_sel == data_demux_pkg::SEL_W'(gi));

        demux_slot #(
          .DW(DW)
        ) u_slot (
          .clk       (clk),
          .rst       (rst),
          .load      (slot_load[gi]),
          .drain     (out_ready[gi]),
          .load_data (in_data),
          .valid     (out_valid[gi]),
          .can_load  (ready_pad[gi]),
          .data      (out_data[gi*DW +: DW])
        );
      end else begin : g_pad
        assign ready_pad[gi] = 1'b1;
      end
    end
  endgenerate

`ifdef DATA_DEMUX_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept && !data_demux_pkg::sel_is_legal(in_sel)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_sel = err_q;
`else
  assign err_sel = 1'b0;
`endif

endmodule

// File: doc/data_demux.md
DATA_DEMUX -- requirements
Module: data_demux

Interface
REQ-001 Parameter DW, default 32: width of every data word.
REQ-002 Parameter NCH, default 7: number of output channels (selects 0..6); fixed at 7 for this CPU.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port in_valid, input, 1: in_data/in_sel are presented.
REQ-006 Port in_ready, output, 1: the word is accepted this cycle when asserted together with in_valid.
REQ-007 Port in_data, input, DW: the word to route.
REQ-008 Port in_sel, input, 3: destination channel, 3'b000..3'b110; 3'b111 is illegal.
REQ-009 Port out_valid, output, NCH: per-channel valid.
REQ-010 Port out_ready, input, NCH: per-channel sink ready.
REQ-011 Port out_data, output, NCH*DW: channel k occupies bits [k*DW+DW-1 : k*DW].
REQ-012 Port err_sel, output, 1: sticky flag, set when an illegal select is accepted.

Function
REQ-013 Each channel SHALL hold a one-entry slot with states EMPTY and FULL.
- EMPTY->FULL on accept to that channel.
- FULL->EMPTY on out_valid&out_ready with no new accept.
- FULL stays FULL on a simultaneous drain and accept.
REQ-014 out_valid[k] SHALL equal slot k FULL, and out_data for channel k SHALL be the slot register; both are registered with no combinational path from in_*.
REQ-015 in_ready SHALL be 1 when the selected slot is EMPTY, or FULL with out_ready[sel] high in the same cycle, or when in_sel=3'b111.
REQ-016 An accepted word SHALL appear on out_valid/out_data of its channel exactly 1 cycle after acceptance.
REQ-017 A simultaneous drain and accept on the same channel SHALL reload the slot with the new word, with no bubble and no loss.
REQ-018 Channels SHALL be independent; a stalled channel SHALL block only inputs selecting it.
REQ-019 Accepting sel=3'b111 SHALL discard the word, change no slot, and take the error action of REQ-025/026.
REQ-020 out_data of an EMPTY channel SHALL hold its last value; sinks may ignore it.
REQ-021 in_ready SHALL depend only on in_sel, slot state and out_ready, never on in_valid.

Reset
REQ-022 While rst=1 at a clock edge: all slots EMPTY, out_valid=0, out_data=0, err_sel=0.
REQ-023 A reset mid-transfer SHALL drop all held words; no acceptance occurs in a reset cycle.
REQ-024 in_ready SHALL be evaluated normally (combinationally) during reset, but no acceptance takes effect.

Configuration
REQ-025 With DATA_DEMUX_ERR_EN defined, accepting sel=3'b111 SHALL set err_sel on the next edge; err_sel holds until rst.
REQ-026 Without DATA_DEMUX_ERR_EN, err_sel SHALL be tied 0 and illegal-select words are silently discarded.

Structure
REQ-027 A shared package SHALL hold NCH, DW default, SEL_ILLEGAL=3'b111 and the slot state encoding (EMPTY=0, FULL=1).
REQ-028 A sub-module demux_slot (one-entry register: load, drain, valid, data) SHALL be instantiated NCH times by generate.

Verification
REQ-029 Write 32'hDEAD_BEEF with sel=2 and all out_ready=0 -> next cycle out_valid=7'b0000100 and channel 2 data=DEADBEEF; a second sel=2 write sees in_ready=0.
REQ-030 Channel 4 FULL, out_ready[4]=1, write 32'h1234 to sel=4 in the same cycle -> in_ready=1; next cycle out_valid[4]=1 and data=0x1234.
REQ-031 Channel 0 FULL and stalled, write 32'h5 to sel=6 -> accepted; channel 6 valid next cycle and channel 0 unchanged.
REQ-032 Write sel=7 with data 32'hFFFF_FFFF -> in_ready=1 and no out_valid change; err_sel=1 next cycle with DATA_DEMUX_ERR_EN, 0 without.
REQ-033 Fill channels 1, 3 and 5, then pulse rst for 1 cycle -> out_valid=0, out_data=0 and err_sel=0 after the edge.
REQ-034 Random traffic for 10k cycles against a per-channel FIFO scoreboard -> no loss, no duplication, per-channel order preserved.
